demux_n: RTL and testbench
==========================

# demux_n

Parametrised 1:NCH demultiplexer, the successor to the fixed 1:2, 8-bit demux. It steers a ready/valid input stream to NCH registered output channels. Two routing modes are supported: round-robin across channels, or addressed by a per-word select. Per-channel backpressure stalls the input only when the target channel is occupied. The block sits between the byte source and the per-lane consumers in the lane-distribution path.

## Interface
Parameters:
- DATA_W, 8, data word width in bits.
- NCH, 4, number of output channels, minimum 2.
- SEL_W, $clog2(NCH), derived localparam; not overridden.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = round-robin (RR), 1 = addressed (ADDR).
- sel_in  in  SEL_W  target channel, used only when mode=1.
- data_in  in  DATA_W  input word.
- valid_in  in  1  input word valid.
- ready_in  out  1  block can accept this cycle.
- data_out  out  NCH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- valid_out  out  NCH  per-channel valid.
- ready_out  in  NCH  per-channel consumer ready.
- err_sel  out  1  one-cycle pulse when an addressed word targets sel_in >= NCH.

## Operation
- Target channel t = (mode ? sel_in : ptr).
- ptr is an internal RR pointer, SEL_W bits wide, with range 0..NCH-1.
- Each channel is a one-entry output register slice holding data and a valid flag.
- ready_in (combinational):
  - 1 if t >= NCH (bad select).
  - Otherwise !valid_out[t] || ready_out[t].
- Accept condition: valid_in && ready_in.
- On accept with t < NCH:
  - slot t loads data_in.
  - valid_out[t] = 1 next cycle.
- On accept with t >= NCH (mode=1 only):
  - The word is dropped.
  - err_sel = 1 next cycle for exactly one cycle.
  - No slot changes.
- Slot drain: if valid_out[k] && ready_out[k] and slot k is not loaded this cycle, valid_out[k] = 0 next cycle. Drain and load in the same cycle leaves valid_out[k] = 1 with the new data.
- Hold: while valid_out[k] && !ready_out[k], data_out[k] stays stable.
- data_out[k] is not cleared on drain. Its value is don't-care while valid_out[k] = 0.
- ptr behaviour:
  - Advances only on an accepted word in mode=0.
  - Wraps from NCH-1 to 0.
  - Holds in mode=1.
  - Never reset by a mode change.
- A mode change takes effect on the same cycle it is sampled. There is no flush.
- Channels not targeted are unaffected. Multiple channels may drain in the same cycle.
- Reset values: valid_out = 0, data_out = 0, ptr = 0, err_sel = 0. ready_in follows its combinational equation from reset state, so it is 1 after reset.

## Timing
- Latency is 1 cycle: a word accepted at edge n appears on data_out[t]/valid_out[t] after edge n.
- Throughput is 1 word/cycle when the target consumer keeps ready_out high or the slot is empty.
- In RR mode with all consumers ready, consecutive words land on channels 0,1,…,NCH-1,0,…
- ready_in depends combinationally on mode, sel_in, ptr, valid_out and ready_out. It does not depend on valid_in.
- Reset asserted mid-operation:
  - Immediately clears all valid_out and err_sel, and sets ptr to 0.
  - Any in-flight word is lost.
  - The first edge after deassertion behaves as if from power-up.
- No combinational path from data_in to data_out.

## Structure
- Package demux_pkg:
  - localparams MODE_RR = 1'b0 and MODE_ADDR = 1'b1.
  - Default DATA_W and NCH values.
- Sub-module demux_slot, instantiated NCH times in a generate loop:
  - Parameter DATA_W.
  - Ports clk, reset, load, data_in, ready_out, valid_out, data_out.
  - Implements load/drain/hold.
- Top-level logic: ptr register, target decode, ready_in mux, err_sel flop.
- The block gets a tb plus probador pair and a synthesized netlist (demux_n_synth), compared against the behavioural model output for output equivalence.

## Test plan
1. **Reset and RR stream.** NCH=4, DATA_W=8, mode=0, all ready_out=1. Pulse reset, then send 0xA0..0xA7 on consecutive cycles. Required:
   - valid_out = 0 and ptr = 0 right after reset.
   - Channel 0 shows 0xA0 then 0xA4; channel 3 shows 0xA3 then 0xA7.
   - Each word appears one cycle after acceptance; ready_in stays 1 throughout.
2. **RR backpressure.** mode=0, ready_out[1]=0, send 0x10, 0x11, 0x12. Required:
   - 0x10 goes to channel 0; 0x11 is held in channel 1.
   - 0x12 goes to channel 2 with ptr=2.
   - After ptr wraps back to 1, ready_in = 0 until ready_out[1] rises. The stalled word then loads on the same cycle channel 1 drains.
3. **Addressed mode.** mode=1, sel_in sequence 3, 3, 0 with data 0x55, 0x66, 0x77, and ready_out[3]=1. Required:
   - Channel 3 shows 0x55 then 0x66 on back-to-back cycles; channel 0 shows 0x77.
   - ptr is unchanged.
4. **Bad select.** NCH=3, mode=1, sel_in=3, data 0xEE. Required:
   - ready_in = 1; err_sel pulses for exactly 1 cycle.
   - No valid_out rises.
5. **Mode switch and mid-stream reset.** Run 3 RR words (ptr=3), switch to mode=1 for 2 words, return to mode=0. Required:
   - The next RR word goes to channel 3.
   - Asserting reset while valid_out=4'b1010 clears valid_out to 0 asynchronously, before the next edge.
6. **Equivalence.** Apply scenarios 1–5 to both the behavioural and synthesized versions. Required: data_out, valid_out, ready_in and err_sel match cycle-for-cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1:NCH lane-distribution demultiplexer.
//   MODE_RR / MODE_ADDR : encodings of the routing-mode input.
//   DEF_DATA_W / DEF_NCH : default word width and channel count.
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NCH    = 4;

endpackage

// File: rtl/demux_n_if.sv
// ---------------------------------------------------------------------------
// demux_n_if
// Bundles the stream-side and channel-side signals of demux_n.
//   mode, sel_in, data_in, valid_in, ready_in : input stream and routing
//   data_out, valid_out, ready_out            : NCH output channels
//   err_sel                                   : bad-select pulse
// Modport slave is the demux itself; master is whoever drives it.
// ---------------------------------------------------------------------------
interface demux_n_if #(
    parameter int DATA_W = 8,
    parameter int NCH    = 4
);
    localparam int SEL_W = $clog2(NCH);

    logic                  mode;
    logic [SEL_W-1:0]      sel_in;
    logic [DATA_W-1:0]     data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [NCH*DATA_W-1:0] data_out;
    logic [NCH-1:0]        valid_out;
    logic [NCH-1:0]        ready_out;
    logic                  err_sel;

    modport slave (
        input  mode, sel_in, data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, err_sel
    );

    modport master (
        output mode, sel_in, data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, err_sel
    );

endinterface

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry output register slice for a single channel.
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture data_in this cycle (wins over a drain)
//   data_in    : word to capture
//   ready_out  : consumer ready; empties the slot when nothing is loaded
//   valid_out  : slot holds a word
//   data_out   : held word (left unchanged on drain)
// ---------------------------------------------------------------------------
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load refills the slot even if it is draining in the same cycle,
    // so a continuously ready consumer sees one word per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/demux_n.sv
// ---------------------------------------------------------------------------
// demux_n
// Steers a ready/valid input stream onto NCH registered output channels,
// either round-robin or addressed by sel_in.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : demux_n_if slave modport (stream in, channels out, err_sel)
// ---------------------------------------------------------------------------
module demux_n
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH
) (
    input  logic       clk,
    input  logic       reset,
    demux_n_if.slave   bus
);

    localparam int SEL_W = $clog2(NCH);
    localparam logic [SEL_W:0]   NCH_X   = (SEL_W+1)'(NCH);
    localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(NCH - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] target;
    logic             badSel;
    logic             accept;
    logic [NCH-1:0]   load;

    // Target decode and ready. A bad select is always accepted so the
    // stream never deadlocks on an unreachable channel; the word is dropped.
    always_comb begin
        target = (bus.mode == MODE_ADDR) ? bus.sel_in : ptr_q;
        badSel = ({1'b0, target} >= NCH_X);
        if (badSel) begin
            bus.ready_in = 1'b1;
        end else begin
            bus.ready_in = !bus.valid_out[target] || bus.ready_out[target];
        end
        accept = bus.valid_in && bus.ready_in;
    end

    // The pointer only moves on words it actually routed, and survives
    // mode changes so RR resumes where it left off.
    always_comb begin
        ptr_d = ptr_q;
        err_d = accept && badSel;
        if (accept && (bus.mode == MODE_RR)) begin
            ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign bus.err_sel = err_q;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign load[k] = accept && !badSel && (target == SEL_W'(k));

        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .data_in   (bus.data_in),
            .ready_out (bus.ready_out[k]),
            .valid_out (bus.valid_out[k]),
            .data_out  (bus.data_out[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_n.sv
// ---------------------------------------------------------------------------
// tb_demux_n
// Drives a 4-channel and a 3-channel demux_n with identical stimulus and
// compares both against a per-channel slot model kept in the bench.
// ---------------------------------------------------------------------------
module tb_demux_n;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [3:0] rdyOut;

    int errors = 0;
    int checks = 0;

    demux_n_if #(.DATA_W(8), .NCH(4)) bus4 ();
    demux_n_if #(.DATA_W(8), .NCH(3)) bus3 ();

    assign bus4.mode      = mode;
    assign bus4.sel_in    = sel;
    assign bus4.data_in   = data;
    assign bus4.valid_in  = valid;
    assign bus4.ready_out = rdyOut;
    assign bus3.mode      = mode;
    assign bus3.sel_in    = sel;
    assign bus3.data_in   = data;
    assign bus3.valid_in  = valid;
    assign bus3.ready_out = rdyOut[2:0];

    demux_n #(.DATA_W(8), .NCH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    demux_n #(.DATA_W(8), .NCH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: index 0 = 4-channel DUT, index 1 = 3-channel DUT.
    bit       mValid [2][4];
    bit [7:0] mData  [2][4];
    int       mPtr   [2];
    bit       mErr   [2];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic getReady(input int d);
        return (d == 0) ? bus4.ready_in : bus3.ready_in;
    endfunction

    function automatic logic getValid(input int d, input int k);
        return (d == 0) ? bus4.valid_out[k] : bus3.valid_out[k];
    endfunction

    function automatic logic [7:0] getData(input int d, input int k);
        return (d == 0) ? bus4.data_out[k*8 +: 8] : bus3.data_out[k*8 +: 8];
    endfunction

    function automatic logic getErr(input int d);
        return (d == 0) ? bus4.err_sel : bus3.err_sel;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mValid[d][k] = 1'b0;
                mData[d][k]  = 8'h00;
            end
            mPtr[d] = 0;
            mErr[d] = 1'b0;
        end
    endtask

    task automatic checkOutputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nch(d); k++) begin
                checks++;
                if (getValid(d, k) !== mValid[d][k]) begin
                    errors++;
                    $display("[TB] FAIL %s valid dut%0d ch%0d got=%b exp=%b", tag, d, k, getValid(d, k), mValid[d][k]);
                end
                if (mValid[d][k]) begin
                    checks++;
                    if (getData(d, k) !== mData[d][k]) begin
                        errors++;
                        $display("[TB] FAIL %s data dut%0d ch%0d got=%h exp=%h", tag, d, k, getData(d, k), mData[d][k]);
                    end
                end
            end
            checks++;
            if (getErr(d) !== mErr[d]) begin
                errors++;
                $display("[TB] FAIL %s err_sel dut%0d got=%b exp=%b", tag, d, getErr(d), mErr[d]);
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check ready_in
    // combinationally, advance the model at the rising edge, then check the
    // registered outputs on the next falling edge.
    task automatic step(input logic m, input logic [1:0] s, input logic [7:0] dt,
                        input logic v, input logic [3:0] ro, input string tag);
        int  t   [2];
        bit  acc [2];
        bit  rdy;
        mode = m; sel = s; data = dt; valid = v; rdyOut = ro;
        #1;
        for (int d = 0; d < 2; d++) begin
            t[d] = m ? int'(s) : mPtr[d];
            rdy  = (t[d] >= nch(d)) ? 1'b1 : (!mValid[d][t[d]] || ro[t[d]]);
            acc[d] = v && rdy;
            checks++;
            if (getReady(d) !== rdy) begin
                errors++;
                $display("[TB] FAIL %s ready_in dut%0d got=%b exp=%b", tag, d, getReady(d), rdy);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nch(d); k++) begin
                if (acc[d] && t[d] == k) begin
                    mValid[d][k] = 1'b1;
                    mData[d][k]  = dt;
                end else if (mValid[d][k] && ro[k]) begin
                    mValid[d][k] = 1'b0;
                end
            end
            mErr[d] = acc[d] && (t[d] >= nch(d));
            if (acc[d] && !m) mPtr[d] = (mPtr[d] + 1) % nch(d);
        end
        @(negedge clk);
        checkOutputs(tag);
    endtask

    // Reset is raised between edges; outputs must clear before any edge.
    task automatic applyReset();
        reset = 1'b1;
        modelReset();
        #1;
        checkOutputs("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        checkOutputs("after_reset");
    endtask

    task automatic test_reset();
        applyReset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nch(d); k++) begin
                checks++;
                if (getData(d, k) !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL reset_data dut%0d ch%0d got=%h exp=00", d, k, getData(d, k));
                end
            end
        end
    endtask

    task automatic test_rr_stream();
        logic [7:0] w;
        applyReset();
        for (int i = 0; i < 8; i++) begin
            w = 8'hA0 + 8'(i);
            step(1'b0, 2'd0, w, 1'b1, 4'hF, "rr_stream");
            if (i == 0 || i == 4 || i == 3 || i == 7) begin
                checks++;
                if (getData(0, i % 4) !== w || getValid(0, i % 4) !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rr_lane ch%0d got=%h/%b exp=%h/1", i % 4, getData(0, i % 4), getValid(0, i % 4), w);
                end
            end
        end
        step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, "rr_stream_idle");
    endtask

    task automatic test_rr_backpressure();
        applyReset();
        step(1'b0, 2'd0, 8'h10, 1'b1, 4'b1101, "rr_bp");
        step(1'b0, 2'd0, 8'h11, 1'b1, 4'b1101, "rr_bp");
        step(1'b0, 2'd0, 8'h12, 1'b1, 4'b1101, "rr_bp");
        step(1'b0, 2'd0, 8'h13, 1'b1, 4'b1101, "rr_bp");
        step(1'b0, 2'd0, 8'h14, 1'b1, 4'b1101, "rr_bp");
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h15, 1'b1, 4'b1101, "rr_bp_stall");
        checks++;
        if (bus4.ready_in !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_bp_stalled got=%b exp=0", bus4.ready_in);
        end
        step(1'b0, 2'd0, 8'h15, 1'b1, 4'b1111, "rr_bp_release");
        checks++;
        if (getData(0, 1) !== 8'h15 || getValid(0, 1) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_bp_reload got=%h/%b exp=15/1", getData(0, 1), getValid(0, 1));
        end
        step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, "rr_bp_idle");
    endtask

    task automatic test_addressed();
        step(1'b1, 2'd3, 8'h55, 1'b1, 4'hF, "addr");
        step(1'b1, 2'd3, 8'h66, 1'b1, 4'hF, "addr");
        checks++;
        if (getData(0, 3) !== 8'h66) begin
            errors++;
            $display("[TB] FAIL addr_b2b got=%h exp=66", getData(0, 3));
        end
        step(1'b1, 2'd0, 8'h77, 1'b1, 4'hF, "addr");
        step(1'b1, 2'd0, 8'h00, 1'b0, 4'hF, "addr_idle");
    endtask

    task automatic test_bad_select();
        applyReset();
        step(1'b1, 2'd3, 8'hEE, 1'b1, 4'hF, "bad_sel");
        checks++;
        if (bus3.err_sel !== 1'b1 || bus3.valid_out !== 3'b000) begin
            errors++;
            $display("[TB] FAIL bad_sel_pulse got=%b/%b exp=1/000", bus3.err_sel, bus3.valid_out);
        end
        step(1'b1, 2'd0, 8'h00, 1'b0, 4'hF, "bad_sel_after");
        checks++;
        if (bus3.err_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_sel_width got=%b exp=0", bus3.err_sel);
        end
    endtask

    task automatic test_mode_switch_reset();
        applyReset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h30 + 8'(i), 1'b1, 4'hF, "ms_rr");
        step(1'b1, 2'd0, 8'h40, 1'b1, 4'hF, "ms_addr");
        step(1'b1, 2'd1, 8'h41, 1'b1, 4'hF, "ms_addr");
        step(1'b0, 2'd0, 8'h50, 1'b1, 4'hF, "ms_back_rr");
        checks++;
        if (getData(0, 3) !== 8'h50 || getValid(0, 3) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ms_resume got=%h/%b exp=50/1", getData(0, 3), getValid(0, 3));
        end
        step(1'b1, 2'd1, 8'h51, 1'b1, 4'h0, "ms_fill");
        checks++;
        if (bus4.valid_out !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL ms_fill got=%b exp=1010", bus4.valid_out);
        end
        #2;
        applyReset();
    endtask

    task automatic test_random();
        applyReset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom), "random");
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; sel = 2'd0; data = 8'h00; valid = 1'b0; rdyOut = 4'hF;
        modelReset();
        @(negedge clk);
        test_reset();
        test_rr_stream();
        test_rr_backpressure();
        test_addressed();
        test_bad_select();
        test_mode_switch_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
